// File: rtl/jtag_uart_avalon_poller.sv
// Avalon-MM master polling the JTAG-UART data register: strobes received bytes to the parser and
// returns one buffered TX byte when WSPACE allows. Optional RX echo: JTAG_UART_RX_ECHO_EN.
module jtag_uart_avalon_poller #(
    parameter int unsigned POLL_INTERVAL = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    output logic        oJTAG_SLAVE_ADDR,
    output logic        oJTAG_SLAVE_RDREQ,
    input  logic [31:0] iJTAG_SLAVE_RDDATA,
    output logic        oJTAG_SLAVE_WRREQ,
    output logic [31:0] oJTAG_SLAVE_WRDATA,
    input  logic        iJTAG_SLAVE_WAIT,
    output logic [7:0]  oDATA_TO_PARSE,
    output logic        oDATA_TO_PARSE_VALID,
    input  logic [7:0]  iTX_BYTE,
    input  logic        iTX_VALID,
    output logic        oTX_READY
);

`ifdef JTAG_UART_RX_ECHO_EN
    localparam bit RxEchoEn = 1'b1;
`else
    localparam bit RxEchoEn = 1'b0;
`endif

    localparam logic [CNT_W-1:0] PollLimit = CNT_W'(POLL_INTERVAL);

    typedef enum logic [1:0] {Idle, RdData, RdCtrl, WrData} stateT;

    stateT            state;
    logic [CNT_W-1:0] pollCnt;
    logic [CNT_W-1:0] pollCntNext;
    logic             burstDrain;
    logic             txPending;
    logic [7:0]       txByte;
    logic             rdAccept;
    logic             wrAccept;
    logic             rxValid;
    logic [15:0]      hiField;
    logic             echoLoad;
    logic             unusedRdBits;

    assign pollCntNext  = pollCnt + CNT_W'(1);
    assign rdAccept     = oJTAG_SLAVE_RDREQ && !iJTAG_SLAVE_WAIT;
    assign wrAccept     = oJTAG_SLAVE_WRREQ && !iJTAG_SLAVE_WAIT;
    assign rxValid      = iJTAG_SLAVE_RDDATA[15];
    assign hiField      = iJTAG_SLAVE_RDDATA[31:16];
    assign echoLoad     = RxEchoEn && (state == RdData) && rdAccept && rxValid;
    assign unusedRdBits = ^iJTAG_SLAVE_RDDATA[14:8];
    assign oTX_READY    = !txPending;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state                <= Idle;
            pollCnt              <= '0;
            burstDrain           <= 1'b0;
            txPending            <= 1'b0;
            txByte               <= 8'h00;
            oJTAG_SLAVE_ADDR     <= 1'b0;
            oJTAG_SLAVE_RDREQ    <= 1'b0;
            oJTAG_SLAVE_WRREQ    <= 1'b0;
            oJTAG_SLAVE_WRDATA   <= 32'h0;
            oDATA_TO_PARSE       <= 8'h00;
            oDATA_TO_PARSE_VALID <= 1'b0;
        end else begin
            oDATA_TO_PARSE_VALID <= 1'b0;
            unique case (state)
                Idle: begin
                    if (burstDrain || (pollCntNext >= PollLimit)) begin
                        state             <= RdData;
                        pollCnt           <= '0;
                        oJTAG_SLAVE_ADDR  <= 1'b0;
                        oJTAG_SLAVE_RDREQ <= 1'b1;
                    end else begin
                        pollCnt <= pollCntNext;
                    end
                end
                RdData: begin
                    if (rdAccept) begin
                        if (rxValid) begin
                            oDATA_TO_PARSE <= iJTAG_SLAVE_RDDATA[7:0];
                        end
                        oDATA_TO_PARSE_VALID <= rxValid;
                        burstDrain           <= rxValid && (hiField > 16'd1);
                        oJTAG_SLAVE_RDREQ    <= 1'b0;
                        state                <= txPending ? RdCtrl : Idle;
                    end
                end
                RdCtrl: begin
                    // Request drops for a cycle between the data and control reads.
                    if (!oJTAG_SLAVE_RDREQ) begin
                        oJTAG_SLAVE_ADDR  <= 1'b1;
                        oJTAG_SLAVE_RDREQ <= 1'b1;
                    end else if (!iJTAG_SLAVE_WAIT) begin
                        oJTAG_SLAVE_RDREQ <= 1'b0;
                        oJTAG_SLAVE_ADDR  <= 1'b0;
                        state             <= (hiField != 16'd0) ? WrData : Idle;
                    end
                end
                WrData: begin
                    if (!oJTAG_SLAVE_WRREQ) begin
                        oJTAG_SLAVE_ADDR   <= 1'b0;
                        oJTAG_SLAVE_WRREQ  <= 1'b1;
                        oJTAG_SLAVE_WRDATA <= {24'h0, txByte};
                    end else if (!iJTAG_SLAVE_WAIT) begin
                        oJTAG_SLAVE_WRREQ <= 1'b0;
                        state             <= Idle;
                    end
                end
                default: state <= Idle;
            endcase

            // Holding register: iTX_VALID wins over echo; loads while full are dropped.
            if ((state == WrData) && wrAccept) begin
                txPending <= 1'b0;
            end else if (!txPending && iTX_VALID) begin
                txByte    <= iTX_BYTE;
                txPending <= 1'b1;
            end else if (!txPending && echoLoad) begin
                txByte    <= iJTAG_SLAVE_RDDATA[7:0];
                txPending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jtag_uart_avalon_poller.sv
// Self-checking bench for jtag_uart_avalon_poller: Avalon slave model with response queues and
// scoreboards for received bytes and transmitted words.
module tb_jtag_uart_avalon_poller;

    logic        iCLK;
    logic        iRST_N;
    logic        oJTAG_SLAVE_ADDR;
    logic        oJTAG_SLAVE_RDREQ;
    logic [31:0] iJTAG_SLAVE_RDDATA;
    logic        oJTAG_SLAVE_WRREQ;
    logic [31:0] oJTAG_SLAVE_WRDATA;
    logic        iJTAG_SLAVE_WAIT;
    logic [7:0]  oDATA_TO_PARSE;
    logic        oDATA_TO_PARSE_VALID;
    logic [7:0]  iTX_BYTE;
    logic        iTX_VALID;
    logic        oTX_READY;

    jtag_uart_avalon_poller #(
        .POLL_INTERVAL(4),
        .CNT_W        (8)
    ) dut (
        .iCLK                (iCLK),
        .iRST_N              (iRST_N),
        .oJTAG_SLAVE_ADDR    (oJTAG_SLAVE_ADDR),
        .oJTAG_SLAVE_RDREQ   (oJTAG_SLAVE_RDREQ),
        .iJTAG_SLAVE_RDDATA  (iJTAG_SLAVE_RDDATA),
        .oJTAG_SLAVE_WRREQ   (oJTAG_SLAVE_WRREQ),
        .oJTAG_SLAVE_WRDATA  (oJTAG_SLAVE_WRDATA),
        .iJTAG_SLAVE_WAIT    (iJTAG_SLAVE_WAIT),
        .oDATA_TO_PARSE      (oDATA_TO_PARSE),
        .oDATA_TO_PARSE_VALID(oDATA_TO_PARSE_VALID),
        .iTX_BYTE            (iTX_BYTE),
        .iTX_VALID           (iTX_VALID),
        .oTX_READY           (oTX_READY)
    );

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    int total = 0;
    int bad   = 0;

    logic [31:0] dataQ[$];
    logic [31:0] ctrlQ[$];
    logic [31:0] wrExp[$];
    logic [7:0]  rxExp[$];

    int   stallLeft   = 0;
    int   wrStallLeft = 0;
    int   dataReads   = 0;
    int   ctrlReads   = 0;
    int   writes      = 0;
    int   gap         = 0;
    int   reqLen      = 0;
    int   lastDataGap = 0;
    int   lastReqLen  = 0;
    logic reqAddr;
    bit   addrMoved;
    bit   lastAddrMoved;
    bit   rvPrev;
    bit   rdyPending;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
        end
    endtask

    function automatic int evCount(input int kind);
        if (kind == 0) return dataReads;
        if (kind == 1) return ctrlReads;
        return writes;
    endfunction

    // kind: 0 data reads, 1 control reads, 2 writes
    task automatic waitEvents(input int kind, input int n);
        int target;
        target = evCount(kind) + n;
        for (int i = 0; i < 300; i++) begin
            @(posedge iCLK);
            #1;
            if (evCount(kind) >= target) return;
        end
        checkVal("timeout", 32'(evCount(kind)), 32'(target));
    endtask

    task automatic sendTx(input logic [7:0] b);
        iTX_BYTE  = b;
        iTX_VALID = 1'b1;
        @(posedge iCLK);
        #1;
        iTX_VALID = 1'b0;
    endtask

    // Slave model plus monitors, evaluated once per cycle on the falling edge.
    initial begin
        iJTAG_SLAVE_WAIT   = 1'b0;
        iJTAG_SLAVE_RDDATA = 32'h0;
        forever begin
            @(negedge iCLK);
            if (!iRST_N) begin
                gap              = 0;
                reqLen           = 0;
                rvPrev           = 1'b0;
                rdyPending       = 1'b0;
                iJTAG_SLAVE_WAIT = 1'b0;
            end else begin
                if (rvPrev || oDATA_TO_PARSE_VALID) begin
                    checkVal("rx_strobe", 32'(oDATA_TO_PARSE_VALID), 32'(rvPrev));
                    if (oDATA_TO_PARSE_VALID) begin
                        checkVal("rx_byte", {24'h0, oDATA_TO_PARSE},
                                 (rxExp.size() > 0) ? {24'h0, rxExp.pop_front()} : 32'hFFFF_FFFF);
                    end
                end
                rvPrev = 1'b0;
                if (rdyPending) begin
                    checkVal("tx_ready_back", 32'(oTX_READY), 32'd1);
                    rdyPending = 1'b0;
                end
                if (oJTAG_SLAVE_RDREQ || oJTAG_SLAVE_WRREQ) begin
                    checkVal("rd_wr_excl", 32'(oJTAG_SLAVE_RDREQ & oJTAG_SLAVE_WRREQ), 32'd0);
                    if (reqLen == 0) begin
                        if (oJTAG_SLAVE_RDREQ && !oJTAG_SLAVE_ADDR) lastDataGap = gap;
                        reqAddr   = oJTAG_SLAVE_ADDR;
                        addrMoved = 1'b0;
                    end else if (oJTAG_SLAVE_ADDR != reqAddr) begin
                        addrMoved = 1'b1;
                    end
                    gap = 0;
                    reqLen++;
                    if (oJTAG_SLAVE_RDREQ) begin
                        if (stallLeft > 0) begin
                            iJTAG_SLAVE_WAIT = 1'b1;
                            stallLeft--;
                        end else begin
                            iJTAG_SLAVE_WAIT = 1'b0;
                            if (oJTAG_SLAVE_ADDR) begin
                                iJTAG_SLAVE_RDDATA = (ctrlQ.size() > 0) ? ctrlQ.pop_front()
                                                                        : 32'h0001_0000;
                                ctrlReads++;
                            end else begin
                                iJTAG_SLAVE_RDDATA = (dataQ.size() > 0) ? dataQ.pop_front()
                                                                        : 32'h0;
                                dataReads++;
                                if (iJTAG_SLAVE_RDDATA[15]) begin
                                    rxExp.push_back(iJTAG_SLAVE_RDDATA[7:0]);
                                    rvPrev = 1'b1;
                                end
                            end
                            lastReqLen    = reqLen;
                            lastAddrMoved = addrMoved;
                            reqLen        = 0;
                        end
                    end else begin
                        if (wrStallLeft > 0) begin
                            iJTAG_SLAVE_WAIT = 1'b1;
                            wrStallLeft--;
                        end else begin
                            iJTAG_SLAVE_WAIT = 1'b0;
                            checkVal("wr_data", oJTAG_SLAVE_WRDATA,
                                     (wrExp.size() > 0) ? wrExp.pop_front() : 32'hFFFF_FFFF);
                            writes++;
                            rdyPending = 1'b1;
                            reqLen     = 0;
                        end
                    end
                end else begin
                    iJTAG_SLAVE_WAIT = 1'b0;
                    gap++;
                end
            end
        end
    end

    initial begin
        int wBase;
        int cBase;
        iRST_N    = 1'b0;
        iTX_BYTE  = 8'h00;
        iTX_VALID = 1'b0;
        repeat (3) @(posedge iCLK);
        #1;
        checkVal("rst_rdreq", 32'(oJTAG_SLAVE_RDREQ), 32'd0);
        checkVal("rst_wrreq", 32'(oJTAG_SLAVE_WRREQ), 32'd0);
        checkVal("rst_addr", 32'(oJTAG_SLAVE_ADDR), 32'd0);
        checkVal("rst_wrdata", oJTAG_SLAVE_WRDATA, 32'd0);
        checkVal("rst_rxdata", 32'(oDATA_TO_PARSE), 32'd0);
        checkVal("rst_rxvalid", 32'(oDATA_TO_PARSE_VALID), 32'd0);
        checkVal("rst_txready", 32'(oTX_READY), 32'd1);
        @(posedge iCLK);
        #2 iRST_N = 1'b1;

        // Basic receive, empty poll, burst drain
        dataQ.push_back(32'h0001_8041);
        waitEvents(0, 1);
        checkVal("gap_reset", 32'(lastDataGap), 32'd4);
        dataQ.push_back(32'h0000_0000);
        waitEvents(0, 1);
        checkVal("gap_single", 32'(lastDataGap), 32'd4);
        dataQ.push_back(32'h0003_80FE);
        dataQ.push_back(32'h0002_8002);
        dataQ.push_back(32'h0001_8010);
        waitEvents(0, 1);
        checkVal("gap_empty", 32'(lastDataGap), 32'd4);
        waitEvents(0, 1);
        checkVal("gap_burst1", 32'(lastDataGap), 32'd1);
        waitEvents(0, 1);
        checkVal("gap_burst2", 32'(lastDataGap), 32'd1);
        waitEvents(0, 1);
        checkVal("gap_burst_end", 32'(lastDataGap), 32'd4);

        // Waitrequest stall on a data read
        stallLeft = 5;
        dataQ.push_back(32'h0001_8077);
        waitEvents(0, 1);
        checkVal("stall_len", 32'(lastReqLen), 32'd6);
        checkVal("stall_addr", 32'(lastAddrMoved), 32'd0);

        // TX with space
        checkVal("tx_ready_idle", 32'(oTX_READY), 32'd1);
        wrExp.push_back(32'h0000_0055);
        ctrlQ.push_back(32'h0040_0000);
        cBase = ctrlReads;
        sendTx(8'h55);
        checkVal("tx_ready_busy", 32'(oTX_READY), 32'd0);
        waitEvents(2, 1);
        checkVal("tx_ctrl_reads", 32'(ctrlReads - cBase), 32'd1);

        // TX with no space, then retry; second load while pending is dropped
        wrExp.push_back(32'h0000_00A5);
        ctrlQ.push_back(32'h0000_0000);
        ctrlQ.push_back(32'h0001_0000);
        wBase = writes;
        cBase = ctrlReads;
        sendTx(8'hA5);
        waitEvents(1, 1);
        checkVal("nospace_nowrite", 32'(writes - wBase), 32'd0);
        checkVal("nospace_ready", 32'(oTX_READY), 32'd0);
        sendTx(8'h66);
        waitEvents(2, 1);
        checkVal("nospace_ctrl_reads", 32'(ctrlReads - cBase), 32'd2);
        repeat (40) @(posedge iCLK);
        #1;
        checkVal("drop_66", 32'(writes - wBase), 32'd1);
        checkVal("tx_ready_end", 32'(oTX_READY), 32'd1);

        // Async reset in the middle of a stalled write
        wrExp.push_back(32'h0000_0033);
        ctrlQ.push_back(32'h0001_0000);
        wrStallLeft = 50;
        wBase = writes;
        sendTx(8'h33);
        for (int i = 0; i < 300 && !oJTAG_SLAVE_WRREQ; i++) begin
            @(posedge iCLK);
            #1;
        end
        checkVal("wr_seen", 32'(oJTAG_SLAVE_WRREQ), 32'd1);
        #2 iRST_N = 1'b0;
        #1;
        checkVal("arst_wrreq", 32'(oJTAG_SLAVE_WRREQ), 32'd0);
        checkVal("arst_rdreq", 32'(oJTAG_SLAVE_RDREQ), 32'd0);
        checkVal("arst_txready", 32'(oTX_READY), 32'd1);
        wrStallLeft = 0;
        wrExp.delete();
        repeat (2) @(posedge iCLK);
        #2 iRST_N = 1'b1;
        waitEvents(0, 1);
        checkVal("gap_post_reset", 32'(lastDataGap), 32'd4);
        repeat (30) @(posedge iCLK);
        #1;
        checkVal("tx_lost", 32'(writes - wBase), 32'd0);
        checkVal("rx_left", 32'(rxExp.size()), 32'd0);
        checkVal("wr_left", 32'(wrExp.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
